i2c_wb_sequencer: RTL and testbench

// - Upstream command sequencer for i2c_master on the I2C2 bus: turns one 32-bit Wishbone write at addr 0x3d

---
 rtl/i2c_seq_pkg.sv | 23 ++
 rtl/i2c_wb_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_wb_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C Wishbone command sequencer.
// Contents:
//   seq_state_e  - sequencer FSM states
//   OP_WRITE     - command opcode for a register write
//   OP_READ      - command opcode for a register read
package i2c_seq_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StWCmd,
      StWReg,
      StWVal,
      StRCmd,
      StRReg,
      StRRcmd,
      StRWait,
      StDone
   } seq_state_e;

   localparam logic [7:0] OP_WRITE = 8'h06;
   localparam logic [7:0] OP_READ  = 8'h07;

endpackage

// File: rtl/i2c_wb_sequencer.sv
// Upstream command sequencer for i2c_master. One Wishbone write to WB_ADDR carrying
// {opcode, dev addr, reg, data} becomes a register-write or register-read cmd/data
// stream for i2c_master; the byte returned by a read is held in rd_data.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wbs_*                 Wishbone slave (address, data, we, stb, cyc, ack)
//   cmd_*                 i2c_master command channel (valid/ready)
//   data_out*             write-byte stream to i2c_master (valid/ready/last)
//   data_in*              read-byte stream from i2c_master (valid/ready/last)
//   missed_ack            NACK pulse from i2c_master
//   rd_data, rd_valid     last read-back byte and its valid level
//   error, busy           status of the last / current command
module i2c_wb_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int unsigned                WB_DATA_WIDTH = 32,
   parameter int unsigned                WB_ADDR_WIDTH = 6,
   parameter logic [WB_ADDR_WIDTH-1:0]   WB_ADDR       = 6'h3d,
   parameter logic [19:0]                TIMEOUT       = 20'hFFFFF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WB_ADDR_WIDTH-1:0] wbs_adr_i,
   input  logic [WB_DATA_WIDTH-1:0] wbs_dat_i,
   input  logic                     wbs_we_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_cyc_i,
   output logic                     wbs_ack_o,
   output logic [6:0]               cmd_address,
   output logic                     cmd_start,
   output logic                     cmd_read,
   output logic                     cmd_write,
   output logic                     cmd_write_multiple,
   output logic                     cmd_stop,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [7:0]               data_out,
   output logic                     data_out_valid,
   output logic                     data_out_last,
   input  logic                     data_out_ready,
   input  logic [7:0]               data_in,
   input  logic                     data_in_valid,
   input  logic                     data_in_last,
   output logic                     data_in_ready,
   input  logic                     missed_ack,
   output logic [7:0]               rd_data,
   output logic                     rd_valid,
   output logic                     error,
   output logic                     busy
);

   seq_state_e  state_q, state_d, state_hs;
   logic [22:0] word_q;
   logic        ack_q;
   logic [7:0]  rd_data_q;
   logic        rd_valid_q;
   logic        error_q;
   logic [19:0] tmo_q, tmo_d;
   logic [7:0]  op;
   logic        accept;
   logic        timeout_hit;
   logic        tmo_abort;
   logic        unused_bits;

   assign op = wbs_dat_i[31:24];

   assign accept = (state_q == StIdle) && wbs_we_i && wbs_stb_i && wbs_cyc_i &&
                   (wbs_adr_i == WB_ADDR) && ((op == OP_WRITE) || (op == OP_READ));

   // Fires on the TIMEOUT-th consecutive cycle spent in the same non-idle state.
   assign timeout_hit = (state_q != StIdle) &&
                        (({1'b0, tmo_q} + 21'd1) >= {1'b0, TIMEOUT});

   // Only abort when no handshake moved the FSM this cycle.
   assign tmo_abort = timeout_hit && (state_hs == state_q);

   assign unused_bits = ^{wbs_dat_i[23], data_in_last};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_hs = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_hs = (op == OP_WRITE) ? StWCmd : StRCmd;
         StWCmd:  if (cmd_ready) state_hs = StWReg;
         StWReg:  if (data_out_ready) state_hs = StWVal;
         StWVal:  if (data_out_ready) state_hs = StDone;
         StRCmd:  if (cmd_ready) state_hs = StRReg;
         StRReg:  if (data_out_ready) state_hs = StRRcmd;
         StRRcmd: if (cmd_ready) state_hs = StRWait;
         StRWait: if (data_in_valid) state_hs = StDone;
         StDone:  state_hs = StIdle;
         default: state_hs = StIdle;
      endcase
      state_d = tmo_abort ? StIdle : state_hs;
   end

   // Output logic
   always_comb begin
      cmd_address        = 7'h00;
      cmd_start          = 1'b0;
      cmd_read           = 1'b0;
      cmd_write          = 1'b0;
      cmd_write_multiple = 1'b0;
      cmd_stop           = 1'b0;
      cmd_valid          = 1'b0;
      data_out           = 8'h00;
      data_out_valid     = 1'b0;
      data_out_last      = 1'b0;
      data_in_ready      = 1'b0;
      case (state_q)
         StWCmd: begin
            cmd_address        = word_q[22:16];
            cmd_start          = 1'b1;
            cmd_write_multiple = 1'b1;
            cmd_stop           = 1'b1;
            cmd_valid          = 1'b1;
         end
         StWReg: begin
            data_out       = word_q[15:8];
            data_out_valid = 1'b1;
         end
         StWVal: begin
            data_out       = word_q[7:0];
            data_out_valid = 1'b1;
            data_out_last  = 1'b1;
         end
         StRCmd: begin
            cmd_address = word_q[22:16];
            cmd_start   = 1'b1;
            cmd_write   = 1'b1;
            cmd_valid   = 1'b1;
         end
         StRReg: begin
            data_out       = word_q[15:8];
            data_out_valid = 1'b1;
            data_out_last  = 1'b1;
         end
         StRRcmd: begin
            cmd_address = word_q[22:16];
            cmd_start   = 1'b1;
            cmd_read    = 1'b1;
            cmd_stop    = 1'b1;
            cmd_valid   = 1'b1;
         end
         StRWait: data_in_ready = 1'b1;
         default: ;
      endcase
      // Reset withdraws any offer in the same cycle; no STOP is sent.
      if (rst) begin
         cmd_valid      = 1'b0;
         data_out_valid = 1'b0;
         data_in_ready  = 1'b0;
      end
      busy = (state_q != StIdle);
   end

   // Timeout counter: cleared on every state change, saturates at TIMEOUT.
   always_comb begin
      if (state_d != state_q) begin
         tmo_d = 20'd0;
      end else if (tmo_q != TIMEOUT) begin
         tmo_d = tmo_q + 20'd1;
      end else begin
         tmo_d = tmo_q;
      end
   end

   // Command latch, ack, read-back and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q     <= 23'd0;
         ack_q      <= 1'b0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         error_q    <= 1'b0;
         tmo_q      <= 20'd0;
      end else begin
         tmo_q <= tmo_d;
         ack_q <= accept;
         if (accept) begin
            word_q <= wbs_dat_i[22:0];
         end
         if (accept) begin
            rd_valid_q <= 1'b0;
         end else if ((state_q == StRWait) && data_in_valid) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= data_in;
         end
         if (accept) begin
            error_q <= 1'b0;
         end else if ((missed_ack && (state_q != StIdle)) || tmo_abort) begin
            error_q <= 1'b1;
         end
      end
   end

   assign wbs_ack_o = ack_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign error     = error_q;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Self-checking bench for i2c_wb_sequencer. A transaction-queue model predicts, every
// cycle, which channel must be offering what, plus busy/ack/rd_*/error levels;
// directed tests add literal expectations on top.
module tb_i2c_wb_sequencer;

   localparam logic [19:0] TMO = 20'd16;

   logic       clk, rst;
   logic [5:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic       wbs_we_i, wbs_stb_i, wbs_cyc_i, wbs_ack_o;
   logic [6:0] cmd_address;
   logic       cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid;
   logic       cmd_ready;
   logic [7:0] data_out;
   logic       data_out_valid, data_out_last, data_out_ready;
   logic [7:0] data_in;
   logic       data_in_valid, data_in_last, data_in_ready;
   logic       missed_ack;
   logic [7:0] rd_data;
   logic       rd_valid, error, busy;

   i2c_wb_sequencer #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_we_i(wbs_we_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_ack_o(wbs_ack_o),
      .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
      .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple),
      .cmd_stop(cmd_stop), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .data_out(data_out), .data_out_valid(data_out_valid),
      .data_out_last(data_out_last), .data_out_ready(data_out_ready),
      .data_in(data_in), .data_in_valid(data_in_valid), .data_in_last(data_in_last),
      .data_in_ready(data_in_ready), .missed_ack(missed_ack),
      .rd_data(rd_data), .rd_valid(rd_valid), .error(error), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: ordered queue of expected transfers ----------------
   typedef enum logic [1:0] {K_CMD, K_BYTE, K_RD} kind_e;
   typedef struct packed {
      kind_e      kind;
      logic [6:0] addr;
      logic [4:0] flags;   // {start, read, write, write_multiple, stop}
      logic [7:0] b;
      logic       last;
   } item_t;

   function automatic item_t mk(kind_e k, logic [6:0] a, logic [4:0] fl, logic [7:0] b,
                                logic l);
      item_t it;
      it.kind = k; it.addr = a; it.flags = fl; it.b = b; it.last = l;
      return it;
   endfunction

   item_t      q[$];
   item_t      f;
   bit         has, was_busy, xfer, n_ack;
   bit         e_cv, e_dv, e_dr;
   bit         m_busy = 0, m_done = 0, m_ack = 0, m_rdv = 0, m_err = 0;
   logic [7:0] m_rdd = 8'h00;
   int         m_wait = 0;

   // observation log for literal checks
   logic [7:0] obs_bytes[$];
   logic       obs_lasts[$];
   logic [6:0] obs_addr;
   logic [4:0] obs_flags[$];
   int         busy_run = 0, last_run = 0;

   // master-side responder knobs
   bit         cmd_en = 1, dat_en = 1, din_en = 0;
   logic [3:0] pat = 4'b1111;
   logic [7:0] din_byte = 8'h00;
   int         cyc_n = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc_n++;
         cmd_ready      = cmd_en && pat[cyc_n % 4];
         data_out_ready = dat_en && pat[cyc_n % 4];
         data_in_valid  = din_en;
         data_in        = din_byte;
      end
   end

   always @(negedge clk) begin
      has = (q.size() != 0);
      f = has ? q[0] : '0;
      e_cv = !rst && has && (f.kind == K_CMD);
      e_dv = !rst && has && (f.kind == K_BYTE);
      e_dr = !rst && has && (f.kind == K_RD);
      chk("cmd_valid", cmd_valid, e_cv);
      chk("data_out_valid", data_out_valid, e_dv);
      chk("data_in_ready", data_in_ready, e_dr);
      if (e_cv)
         chk("cmd_fields", {cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple,
             cmd_stop}, {f.addr, f.flags});
      if (e_dv) chk("data_out_fields", {data_out, data_out_last}, {f.b, f.last});
      chk("busy", busy, m_busy);
      chk("wbs_ack", wbs_ack_o, m_ack);
      chk("rd_valid", rd_valid, m_rdv);
      chk("rd_data", rd_data, m_rdd);
      chk("error", error, m_err);

      if (cmd_valid && cmd_ready) begin
         obs_addr = cmd_address;
         obs_flags.push_back({cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop});
      end
      if (data_out_valid && data_out_ready) begin
         obs_bytes.push_back(data_out);
         obs_lasts.push_back(data_out_last);
      end
      if (busy) busy_run++;
      else if (busy_run != 0) begin
         last_run = busy_run;
         busy_run = 0;
      end

      was_busy = m_busy;
      if (rst) begin
         q.delete();
         m_busy = 0; m_done = 0; m_ack = 0; m_rdv = 0; m_err = 0; m_rdd = 8'h00; m_wait = 0;
      end else begin
         n_ack = 0;
         if (was_busy && missed_ack) m_err = 1;
         if (m_done) begin
            m_done = 0;
            m_busy = 0;
         end else if (has) begin
            xfer = ((f.kind == K_CMD) && cmd_ready) || ((f.kind == K_BYTE) && data_out_ready) ||
                   ((f.kind == K_RD) && data_in_valid);
            if (xfer) begin
               if (f.kind == K_RD) begin
                  m_rdd = data_in;
                  m_rdv = 1;
               end
               void'(q.pop_front());
               m_wait = 0;
               if (q.size() == 0) m_done = 1;
            end else begin
               m_wait++;
               if (m_wait >= int'(TMO)) begin
                  q.delete();
                  m_busy = 0;
                  m_err = 1;
                  m_wait = 0;
               end
            end
         end
         if (!was_busy && wbs_we_i && wbs_stb_i && wbs_cyc_i && (wbs_adr_i == 6'h3d) &&
             ((wbs_dat_i[31:24] == 8'h06) || (wbs_dat_i[31:24] == 8'h07))) begin
            if (wbs_dat_i[31:24] == 8'h06) begin
               q.push_back(mk(K_CMD, wbs_dat_i[22:16], 5'b10011, 8'h00, 1'b0));
               q.push_back(mk(K_BYTE, 7'h00, 5'b00000, wbs_dat_i[15:8], 1'b0));
               q.push_back(mk(K_BYTE, 7'h00, 5'b00000, wbs_dat_i[7:0], 1'b1));
            end else begin
               q.push_back(mk(K_CMD, wbs_dat_i[22:16], 5'b10100, 8'h00, 1'b0));
               q.push_back(mk(K_BYTE, 7'h00, 5'b00000, wbs_dat_i[15:8], 1'b1));
               q.push_back(mk(K_CMD, wbs_dat_i[22:16], 5'b11001, 8'h00, 1'b0));
               q.push_back(mk(K_RD, 7'h00, 5'b00000, 8'h00, 1'b0));
            end
            m_busy = 1; m_rdv = 0; m_err = 0; m_wait = 0; n_ack = 1;
         end
         m_ack = n_ack;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wb_cmd(input logic [31:0] w, input int hold, output bit acked,
                         output int lat);
      @(posedge clk);
      #1;
      wbs_adr_i = 6'h3d; wbs_dat_i = w; wbs_we_i = 1; wbs_stb_i = 1; wbs_cyc_i = 1;
      acked = 0;
      lat = -1;
      for (int i = 0; i < hold && !acked; i++) begin
         @(negedge clk);
         if (wbs_ack_o) begin
            acked = 1;
            lat = i;
         end
      end
      @(posedge clk);
      #1;
      wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      chk(name, ok, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      obs_bytes.delete();
      obs_lasts.delete();
      obs_flags.delete();
      obs_addr = 7'h00;
   endtask

   bit acked;
   int lat;
   bit seen;

   initial begin
      rst = 1;
      wbs_adr_i = 0; wbs_dat_i = 0; wbs_we_i = 0; wbs_stb_i = 0; wbs_cyc_i = 0;
      cmd_ready = 0; data_out_ready = 0; data_in = 0; data_in_valid = 0;
      data_in_last = 0; missed_ack = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("reset_outputs", {wbs_ack_o, busy, rd_valid, error, cmd_valid, data_out_valid,
          data_in_ready, rd_data}, 32'h0);

      // register write with every-other-cycle ready
      pat = 4'b1010;
      clear_obs();
      wb_cmd(32'h065A1234, 8, acked, lat);
      chk("wr_acked", acked, 1);
      chk("wr_ack_latency", lat, 1);
      wait_idle("wr_idle");
      chk("wr_addr", obs_addr, 7'h5A);
      chk("wr_cmd_flags", obs_flags[0], 5'b10011);
      chk("wr_byte_count", obs_bytes.size(), 2);
      chk("wr_byte0", {obs_bytes[0], obs_lasts[0]}, {8'h12, 1'b0});
      chk("wr_byte1", {obs_bytes[1], obs_lasts[1]}, {8'h34, 1'b1});

      // register read, master returns 0xC3 (data_in_valid also raised early as stray)
      din_byte = 8'hC3;
      din_en = 1;
      clear_obs();
      wb_cmd(32'h075A2000, 8, acked, lat);
      chk("rd_acked", acked, 1);
      wait_idle("rd_idle");
      din_en = 0;
      chk("rd_cmds", {obs_flags[0], obs_flags[1]}, {5'b10100, 5'b11001});
      chk("rd_reg_byte", {obs_bytes[0], obs_lasts[0]}, {8'h20, 1'b1});
      chk("rd_result", {rd_valid, rd_data}, {1'b1, 8'hC3});

      // command while busy, then illegal opcode while idle
      pat = 4'b1111;
      cmd_en = 0;
      wb_cmd(32'h065A0102, 8, acked, lat);
      chk("busy_first_acked", acked, 1);
      wb_cmd(32'h06112233, 6, acked, lat);
      chk("busy_second_no_ack", acked, 0);
      cmd_en = 1;
      wait_idle("busy_idle");
      wb_cmd(32'h055A0102, 6, acked, lat);
      chk("bad_opcode_no_ack", acked, 0);
      chk("bad_opcode_busy", busy, 0);

      // timeout with cmd_ready stuck low
      cmd_en = 0;
      wb_cmd(32'h065A4455, 8, acked, lat);
      wait_idle("tmo_idle");
      chk("tmo_busy_cycles", last_run, 16);
      chk("tmo_error", error, 1);
      cmd_en = 1;
      wb_cmd(32'h065A6677, 8, acked, lat);
      wait_idle("tmo_recover_idle");
      chk("tmo_recover_error", error, 0);

      // NACK during the register byte
      dat_en = 0;
      clear_obs();
      wb_cmd(32'h065A7788, 8, acked, lat);
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (data_out_valid) seen = 1;
      end
      chk("nack_reached_wreg", seen, 1);
      @(posedge clk);
      #1 missed_ack = 1;
      @(posedge clk);
      #1 missed_ack = 0;
      dat_en = 1;
      wait_idle("nack_idle");
      chk("nack_error", error, 1);
      chk("nack_bytes", {obs_bytes[0], obs_bytes[1]}, {8'h77, 8'h88});

      // reset while waiting for the read byte
      wb_cmd(32'h075A3000, 8, acked, lat);
      seen = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         if (data_in_ready) seen = 1;
      end
      chk("rst_reached_rwait", seen, 1);
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_outputs", {wbs_ack_o, busy, rd_valid, error, cmd_valid, data_out_valid,
          data_in_ready, rd_data}, 32'h0);
      din_byte = 8'h5E;
      din_en = 1;
      wb_cmd(32'h075A3000, 8, acked, lat);
      wait_idle("rst_read_idle");
      chk("rst_read_result", {rd_valid, rd_data, error}, {1'b1, 8'h5E, 1'b0});
      din_en = 0;

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
